// File: rtl/turn_throw_fsm.sv
// turn_throw_fsm: runs one throw turn for the local or remote player.
//
// Waits for a fresh press, charges a saturating power meter while the press is
// held, and latches the power on release or hold timeout. It then holds
// throw_enable for THROW_CYCLES cycles and pulses turn_done for one cycle.
//
// Ports:
//   clk           system clock
//   rst           synchronous reset, active-high
//   my_turn       turn ownership; low aborts the turn on the next edge
//   local_mode    1: press = space, 0: press = space_rx
//   space         local key (already synchronised)
//   space_rx      remote player press (already synchronised)
//   enable_draw   power-bar draw enable (CHARGE)
//   index         sprite/phase index: 0 idle, 1 charge, 2 throw/done
//   space_pin_tx  local press forwarded to the remote board (CHARGE, local mode)
//   throw_enable  projectile motion enable (THROW)
//   throw_power   power latched at release
//   turn_done     one-cycle end-of-turn pulse (DONE)
module turn_throw_fsm #(
   parameter int unsigned THROW_CYCLES      = 65000000,
   parameter int unsigned POWER_W           = 4,
   parameter int unsigned POWER_STEP_CYCLES = 4062500,
   parameter int unsigned MAX_HOLD_CYCLES   = 130000000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               my_turn,
   input  logic               local_mode,
   input  logic               space,
   input  logic               space_rx,
   output logic               enable_draw,
   output logic [1:0]         index,
   output logic               space_pin_tx,
   output logic               throw_enable,
   output logic [POWER_W-1:0] throw_power,
   output logic               turn_done
);

   localparam logic [31:0]        ThrLast  = THROW_CYCLES - 1;
   localparam logic [31:0]        StepLast = POWER_STEP_CYCLES - 1;
   localparam logic [31:0]        HoldLast = MAX_HOLD_CYCLES - 1;
   localparam logic [POWER_W-1:0] PowerMax = {POWER_W{1'b1}};

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StCharge = 2'd1,
      StThrow  = 2'd2,
      StDone   = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic               press;
   logic               press_q;
   logic               start;
   logic [31:0]        step_cnt_q, step_cnt_d;
   logic [31:0]        hold_cnt_q, hold_cnt_d;
   logic [31:0]        thr_cnt_q, thr_cnt_d;
   logic [POWER_W-1:0] power_q, power_d;
   logic [POWER_W-1:0] throw_power_q, throw_power_d;

   assign press = local_mode ? space : space_rx;
   // Rising edge only: a key held across a turn, abort or reset never starts a turn.
   assign start = press & ~press_q;

   // Next-state logic
   always_comb begin
      state_d       = state_q;
      step_cnt_d    = step_cnt_q;
      hold_cnt_d    = hold_cnt_q;
      thr_cnt_d     = thr_cnt_q;
      power_d       = power_q;
      throw_power_d = throw_power_q;

      if (!my_turn) begin
         // Abort wins over every other event, including the DONE pulse.
         state_d       = StIdle;
         step_cnt_d    = '0;
         hold_cnt_d    = '0;
         thr_cnt_d     = '0;
         power_d       = '0;
         throw_power_d = '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (start) begin
                  state_d       = StCharge;
                  step_cnt_d    = '0;
                  hold_cnt_d    = '0;
                  power_d       = '0;
                  throw_power_d = '0;
               end
            end
            StCharge: begin
               if (!press || (hold_cnt_q == HoldLast)) begin
                  // Release (or timeout) latches the current power; the
                  // increment that would land on this edge is dropped.
                  state_d       = StThrow;
                  throw_power_d = power_q;
                  thr_cnt_d     = '0;
               end else begin
                  hold_cnt_d = hold_cnt_q + 32'd1;
                  if (step_cnt_q == StepLast) begin
                     step_cnt_d = '0;
                     if (power_q != PowerMax) begin
                        power_d = power_q + POWER_W'(1);
                     end
                  end else begin
                     step_cnt_d = step_cnt_q + 32'd1;
                  end
               end
            end
            StThrow: begin
               if (thr_cnt_q == ThrLast) begin
                  state_d = StDone;
               end else begin
                  thr_cnt_d = thr_cnt_q + 32'd1;
               end
            end
            StDone: begin
               state_d = StIdle;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   // Outputs decoded from the registered state
   always_comb begin
      enable_draw  = 1'b0;
      index        = 2'd0;
      space_pin_tx = 1'b0;
      throw_enable = 1'b0;
      turn_done    = 1'b0;
      case (state_q)
         StCharge: begin
            enable_draw  = 1'b1;
            index        = 2'd1;
            space_pin_tx = local_mode;
         end
         StThrow: begin
            index        = 2'd2;
            throw_enable = 1'b1;
         end
         StDone: begin
            index     = 2'd2;
            turn_done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign throw_power = throw_power_q;

   always_ff @(posedge clk) begin
      // press_q keeps sampling during reset so a key held through reset must
      // be released and pressed again before a turn starts.
      press_q <= press;
      if (rst) begin
         state_q       <= StIdle;
         step_cnt_q    <= '0;
         hold_cnt_q    <= '0;
         thr_cnt_q     <= '0;
         power_q       <= '0;
         throw_power_q <= '0;
      end else begin
         state_q       <= state_d;
         step_cnt_q    <= step_cnt_d;
         hold_cnt_q    <= hold_cnt_d;
         thr_cnt_q     <= thr_cnt_d;
         power_q       <= power_d;
         throw_power_q <= throw_power_d;
      end
   end

endmodule

// File: tb/tb_turn_throw_fsm.sv
// Self-checking bench for turn_throw_fsm with small parameters. Expected
// outputs come from a timeline model: a turn whose press lasts P cycles spends
// n = min(P, MAX_HOLD) cycles charging and earns min((n-1)/STEP, 2^W-1) power.
module tb_turn_throw_fsm;

   localparam int unsigned Thr  = 10;
   localparam int unsigned Pw   = 3;
   localparam int unsigned Step = 4;
   localparam int unsigned Hold = 40;
   localparam int          PMax = 7;

   logic          clk = 1'b0;
   logic          rst;
   logic          my_turn;
   logic          local_mode;
   logic          space;
   logic          space_rx;
   logic          enable_draw;
   logic [1:0]    index;
   logic          space_pin_tx;
   logic          throw_enable;
   logic [Pw-1:0] throw_power;
   logic          turn_done;
   logic [8:0]    obs;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   turn_throw_fsm #(
      .THROW_CYCLES      (Thr),
      .POWER_W           (Pw),
      .POWER_STEP_CYCLES (Step),
      .MAX_HOLD_CYCLES   (Hold)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .my_turn      (my_turn),
      .local_mode   (local_mode),
      .space        (space),
      .space_rx     (space_rx),
      .enable_draw  (enable_draw),
      .index        (index),
      .space_pin_tx (space_pin_tx),
      .throw_enable (throw_enable),
      .throw_power  (throw_power),
      .turn_done    (turn_done)
   );

   assign obs = {enable_draw, index, space_pin_tx, throw_enable, throw_power, turn_done};

   // Expected outputs j cycles after the start edge of a turn.
   function automatic logic [8:0] model_vec(input int j, input int n, input int pow,
                                            input logic lm);
      logic [2:0] p;
      p = pow[2:0];
      if (j < n)               return {1'b1, 2'd1, lm,   1'b0, 3'd0, 1'b0};
      else if (j < n + Thr)    return {1'b0, 2'd2, 1'b0, 1'b1, p,    1'b0};
      else if (j == n + Thr)   return {1'b0, 2'd2, 1'b0, 1'b0, p,    1'b1};
      else                     return {1'b0, 2'd0, 1'b0, 1'b0, p,    1'b0};
   endfunction

   function automatic int charge_len(input int p);
      return (p < Hold) ? p : Hold;
   endfunction

   function automatic int power_of(input int n);
      int v;
      v = (n - 1) / Step;
      return (v > PMax) ? PMax : v;
   endfunction

   // Drive the selected press line; the unselected line gets noise.
   task automatic set_press(input logic lm, input logic v);
      local_mode = lm;
      if (lm) begin
         space    = v;
         space_rx = 1'($urandom);
      end else begin
         space_rx = v;
         space    = 1'($urandom);
      end
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      my_turn    = 1'b1;
      local_mode = 1'b1;
      space      = 1'b0;
      space_rx   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (obs !== 9'd0) begin
         n_bad++;
         $display("FAIL reset_state got=%b exp=%b", obs, 9'd0);
      end
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_cmp++;
         if (obs !== 9'd0) begin
            n_bad++;
            $display("FAIL reset_idle i=%0d got=%b exp=%b", i, obs, 9'd0);
         end
      end
   endtask

   // Remote mode: the local key must not start a turn.
   task automatic test_remote_ignore();
      local_mode = 1'b0;
      space_rx   = 1'b0;
      for (int i = 0; i < 10; i++) begin
         space = 1'($urandom);
         @(negedge clk);
         n_cmp++;
         if (obs !== 9'd0) begin
            n_bad++;
            $display("FAIL remote_ignore i=%0d got=%b exp=%b", i, obs, 9'd0);
         end
      end
      space = 1'b0;
      @(negedge clk);
   endtask

   // Full turns: a directed table followed by random press lengths/modes.
   task automatic test_turns();
      int   tbl_p [6] = '{9, 60, 5, 1, 40, 41};
      logic tbl_m [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int t = 0; t < 18; t++) begin
         int   p, n, pow, last;
         logic lm;
         if (t < 6) begin
            p  = tbl_p[t];
            lm = tbl_m[t];
         end else begin
            p  = int'($urandom_range(1, 60));
            lm = 1'($urandom);
         end
         n    = charge_len(p);
         pow  = power_of(n);
         last = (n + Thr + 3 > p + 2) ? n + Thr + 3 : p + 2;
         @(negedge clk);
         set_press(lm, 1'b1);
         for (int j = 0; j <= last; j++) begin
            logic [8:0] exp;
            @(negedge clk);
            exp = model_vec(j, n, pow, lm);
            n_cmp++;
            if (obs !== exp) begin
               n_bad++;
               $display("FAIL turn P=%0d lm=%0b j=%0d got=%b exp=%b", p, lm, j, obs, exp);
            end
            set_press(lm, (j + 1 < p));
         end
      end
   endtask

   // Abort at a chosen cycle, then check the held key cannot restart the turn.
   task automatic test_abort();
      for (int it = 0; it < 5; it++) begin
         int   p, n, pow, a;
         logic lm;
         logic [8:0] exp;
         p   = (it == 0) ? 9 : int'($urandom_range(1, 45));
         lm  = (it == 0) ? 1'b1 : 1'($urandom);
         n   = charge_len(p);
         pow = power_of(n);
         a   = (it == 0) ? n + 4 : int'($urandom_range(0, n + Thr));
         @(negedge clk);
         set_press(lm, 1'b1);
         for (int j = 0; j <= a; j++) begin
            @(negedge clk);
            exp = model_vec(j, n, pow, lm);
            n_cmp++;
            if (obs !== exp) begin
               n_bad++;
               $display("FAIL abort_pre a=%0d j=%0d got=%b exp=%b", a, j, obs, exp);
            end
            set_press(lm, (j + 1 < p));
            if (j == a) my_turn = 1'b0;
         end
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== 9'd0) begin
               n_bad++;
               $display("FAIL abort_clear a=%0d i=%0d got=%b exp=%b", a, i, obs, 9'd0);
            end
            set_press(lm, 1'b1);
            if (i == 2) my_turn = 1'b1;
         end
         // Release and press again: a new charge must start.
         set_press(lm, 1'b0);
         @(negedge clk);
         set_press(lm, 1'b1);
         @(negedge clk);
         exp = {1'b1, 2'd1, lm, 1'b0, 3'd0, 1'b0};
         n_cmp++;
         if (obs !== exp) begin
            n_bad++;
            $display("FAIL abort_repress a=%0d got=%b exp=%b", a, obs, exp);
         end
         my_turn = 1'b0;
         set_press(lm, 1'b0);
         @(negedge clk);
         my_turn = 1'b1;
      end
   endtask

   // Reset during CHARGE cycle 6 with the key still held afterwards.
   task automatic test_reset_mid();
      logic [8:0] exp;
      @(negedge clk);
      set_press(1'b1, 1'b1);
      for (int j = 0; j <= 6; j++) begin
         @(negedge clk);
         exp = model_vec(j, Hold, 0, 1'b1);
         n_cmp++;
         if (obs !== exp) begin
            n_bad++;
            $display("FAIL reset_mid_pre j=%0d got=%b exp=%b", j, obs, exp);
         end
      end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (obs !== 9'd0) begin
         n_bad++;
         $display("FAIL reset_mid_clear got=%b exp=%b", obs, 9'd0);
      end
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_cmp++;
         if (obs !== 9'd0) begin
            n_bad++;
            $display("FAIL reset_held_key i=%0d got=%b exp=%b", i, obs, 9'd0);
         end
      end
      set_press(1'b1, 1'b0);
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_remote_ignore();
      test_turns();
      test_abort();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
